// File: rtl/add_tree_pkg.sv
// Shared widths, defaults and elaboration helpers for the pipelined adder tree.
// Defaults match the motion-estimation SAD datapath (14-bit |diff|, 8 per row).
package add_tree_pkg;

  localparam int DEF_EBD = 14;
  localparam int DEF_N   = 8;
  localparam int DEF_OBD = 17;
  localparam int MAX_N   = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Element count must split evenly at every tree level.
  function automatic bit params_ok(input int ebd, input int n, input int obd);
    return (ebd > 0) && (n >= 2) && (n <= MAX_N) && ((n & (n - 1)) == 0) && (obd >= ebd);
  endfunction

endpackage

// File: rtl/add_tree_level.sv
// One registered pairwise-add level: PAIRS sums of IN_W-bit operands, 1 bit wider out.
// Flags travel alongside the sums; everything holds while adv is low.
module add_tree_level
  import add_tree_pkg::*;
#(
  parameter int IN_W  = DEF_EBD,
  parameter int PAIRS = DEF_N / 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      adv,
  input  logic [2*PAIRS*IN_W-1:0]   in_dat,
  input  logic                      in_vld,
  input  logic                      in_first,
  input  logic                      in_last,
  output logic [PAIRS*(IN_W+1)-1:0] out_dat,
  output logic                      out_vld,
  output logic                      out_first,
  output logic                      out_last
);

  localparam int OUT_W = IN_W + 1;

  logic [PAIRS*OUT_W-1:0] sum_d, sum_q;
  logic                   vld_d, vld_q;
  logic                   first_d, first_q;
  logic                   last_d, last_q;

  always_comb begin
    sum_d   = sum_q;
    vld_d   = vld_q;
    first_d = first_q;
    last_d  = last_q;
    if (adv) begin
      vld_d   = in_vld;
      first_d = in_first;
      last_d  = in_last;
      // Bubbles leave the data registers untouched to avoid needless toggling.
      if (in_vld) begin
        for (int p = 0; p < PAIRS; p++) begin
          sum_d[p*OUT_W +: OUT_W] = OUT_W'(in_dat[2*p*IN_W +: IN_W])
                                  + OUT_W'(in_dat[(2*p+1)*IN_W +: IN_W]);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign out_dat   = sum_q;
  assign out_vld   = vld_q;
  assign out_first = first_q;
  assign out_last  = last_q;

endmodule

// File: rtl/add_tree_acc.sv
// Pipelined unsigned adder tree with first/last block accumulation and saturate/wrap output.
// Latency log2(N)+1 cycles; any output back-pressure stalls every stage at once.
module add_tree_acc
  import add_tree_pkg::*;
#(
  parameter int ELEMENT_BIT_DEPTH = DEF_EBD,
  parameter int NUM_ELEMENTS      = DEF_N,
  parameter int OUT_BIT_DEPTH     = DEF_OBD,
  parameter int SATURATE          = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [ELEMENT_BIT_DEPTH*NUM_ELEMENTS-1:0] addend_array,
  input  logic                                    in_valid,
  input  logic                                    in_first,
  input  logic                                    in_last,
  output logic                                    in_ready,
  output logic [OUT_BIT_DEPTH-1:0]                out_sum,
  output logic                                    out_sat,
  output logic                                    out_valid,
  input  logic                                    out_ready
);

  localparam int L      = clog2(NUM_ELEMENTS);
  localparam int TREE_W = ELEMENT_BIT_DEPTH + L;
  localparam int FULL_W = OUT_BIT_DEPTH + ELEMENT_BIT_DEPTH + L + 1;
  localparam logic [OUT_BIT_DEPTH-1:0] OUT_MAX = '1;

  if (!params_ok(ELEMENT_BIT_DEPTH, NUM_ELEMENTS, OUT_BIT_DEPTH)) begin : g_bad_params
    $error("add_tree_acc: NUM_ELEMENTS must be a power of 2 in 2..64 and OUT_BIT_DEPTH >= ELEMENT_BIT_DEPTH");
  end

  logic adv;
  logic out_valid_d, out_valid_q;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int IN_W  = ELEMENT_BIT_DEPTH + k;
    localparam int PAIRS = NUM_ELEMENTS >> (k + 1);

    logic [2*PAIRS*IN_W-1:0]   src_dat;
    logic                      src_vld, src_first, src_last;
    logic [PAIRS*(IN_W+1)-1:0] lvl_dat;
    logic                      lvl_vld, lvl_first, lvl_last;

    if (k == 0) begin : g_head
      assign src_dat   = addend_array;
      assign src_vld   = in_valid;
      assign src_first = in_first;
      assign src_last  = in_last;
    end else begin : g_link
      assign src_dat   = g_lvl[k-1].lvl_dat;
      assign src_vld   = g_lvl[k-1].lvl_vld;
      assign src_first = g_lvl[k-1].lvl_first;
      assign src_last  = g_lvl[k-1].lvl_last;
    end

    add_tree_level #(
      .IN_W  (IN_W),
      .PAIRS (PAIRS)
    ) u_level (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv),
      .in_dat    (src_dat),
      .in_vld    (src_vld),
      .in_first  (src_first),
      .in_last   (src_last),
      .out_dat   (lvl_dat),
      .out_vld   (lvl_vld),
      .out_first (lvl_first),
      .out_last  (lvl_last)
    );
  end

  logic [TREE_W-1:0] tree_sum;
  logic              tree_vld, tree_first, tree_last;

  assign tree_sum   = g_lvl[L-1].lvl_dat;
  assign tree_vld   = g_lvl[L-1].lvl_vld;
  assign tree_first = g_lvl[L-1].lvl_first;
  assign tree_last  = g_lvl[L-1].lvl_last;

  logic [OUT_BIT_DEPTH-1:0] acc_d, acc_q;
  logic                     sat_acc_d, sat_acc_q;
  logic [OUT_BIT_DEPTH-1:0] out_sum_d, out_sum_q;
  logic                     out_sat_d, out_sat_q;
  logic [OUT_BIT_DEPTH-1:0] acc_base;
  logic [FULL_W-1:0]        full;
  logic                     ovf;
  logic [OUT_BIT_DEPTH-1:0] acc_next;
  logic                     sat_next;

  always_comb begin
    acc_base  = tree_first ? '0 : acc_q;
    full      = FULL_W'(acc_base) + FULL_W'(tree_sum);
    ovf       = full > FULL_W'(OUT_MAX);
    acc_next  = ((SATURATE != 0) && ovf) ? OUT_MAX : full[OUT_BIT_DEPTH-1:0];
    sat_next  = (~tree_first & sat_acc_q) | ovf;

    acc_d       = acc_q;
    sat_acc_d   = sat_acc_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    out_valid_d = out_valid_q;
    if (adv) begin
      // adv with out_valid high implies the consumer took the current result.
      out_valid_d = 1'b0;
      if (tree_vld) begin
        acc_d     = acc_next;
        sat_acc_d = sat_next;
        if (tree_last) begin
          out_sum_d   = acc_next;
          out_sat_d   = sat_next;
          out_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sat_acc_q   <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sat_acc_q   <= sat_acc_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_tree_acc.sv
// Five adder-tree configurations fed one shared beat stream, checked each cycle against a block-sum model.
module tb_add_tree_acc;

  localparam int ND  = 5;
  localparam int EBD = 14;
  localparam int NEL  [ND] = '{8, 8, 8, 16, 2};
  localparam int OBD  [ND] = '{17, 14, 14, 17, 15};
  localparam int SATM [ND] = '{1, 1, 0, 1, 0};
  localparam int LAT  [ND] = '{4, 4, 4, 5, 2};

  typedef struct {
    longint sum;
    bit     sat;
    int     cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [EBD-1:0] el [16];
  logic [16*EBD-1:0] vec;
  logic stim_vld = 1'b0, stim_first = 1'b0, stim_last = 1'b0;
  logic out_rdy = 1'b1;
  logic dut_vld;
  logic rdy_all;
  logic [ND-1:0] in_rdy, o_vld, o_sat;
  logic [17:0] o_sum [ND];
  logic [16:0] s0, s3;
  logic [13:0] s1, s2;
  logic [14:0] s4;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit lat_chk = 1'b1;
  bit auto_release = 1'b0;
  bit fresh [ND];
  int dcnt [ND];
  longint last_sum [ND];
  bit last_sat [ND];
  longint acc [ND];
  bit sacc [ND];
  exp_t expq [ND][$];
  logic [EBD-1:0] base_v [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    vec = '0;
    for (int i = 0; i < 16; i++) vec[i*EBD +: EBD] = el[i];
  end

  assign rdy_all = &in_rdy;
  assign dut_vld = stim_vld & rdy_all;
  assign o_sum[0] = 18'(s0);
  assign o_sum[1] = 18'(s1);
  assign o_sum[2] = 18'(s2);
  assign o_sum[3] = 18'(s3);
  assign o_sum[4] = 18'(s4);

  add_tree_acc #(.ELEMENT_BIT_DEPTH(EBD), .NUM_ELEMENTS(8), .OUT_BIT_DEPTH(17), .SATURATE(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .addend_array(vec[8*EBD-1:0]), .in_valid(dut_vld),
    .in_first(stim_first), .in_last(stim_last), .in_ready(in_rdy[0]), .out_sum(s0),
    .out_sat(o_sat[0]), .out_valid(o_vld[0]), .out_ready(out_rdy));
  add_tree_acc #(.ELEMENT_BIT_DEPTH(EBD), .NUM_ELEMENTS(8), .OUT_BIT_DEPTH(14), .SATURATE(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .addend_array(vec[8*EBD-1:0]), .in_valid(dut_vld),
    .in_first(stim_first), .in_last(stim_last), .in_ready(in_rdy[1]), .out_sum(s1),
    .out_sat(o_sat[1]), .out_valid(o_vld[1]), .out_ready(out_rdy));
  add_tree_acc #(.ELEMENT_BIT_DEPTH(EBD), .NUM_ELEMENTS(8), .OUT_BIT_DEPTH(14), .SATURATE(0)) u_d2 (
    .clk(clk), .rst_n(rst_n), .addend_array(vec[8*EBD-1:0]), .in_valid(dut_vld),
    .in_first(stim_first), .in_last(stim_last), .in_ready(in_rdy[2]), .out_sum(s2),
    .out_sat(o_sat[2]), .out_valid(o_vld[2]), .out_ready(out_rdy));
  add_tree_acc #(.ELEMENT_BIT_DEPTH(EBD), .NUM_ELEMENTS(16), .OUT_BIT_DEPTH(17), .SATURATE(1)) u_d3 (
    .clk(clk), .rst_n(rst_n), .addend_array(vec), .in_valid(dut_vld),
    .in_first(stim_first), .in_last(stim_last), .in_ready(in_rdy[3]), .out_sum(s3),
    .out_sat(o_sat[3]), .out_valid(o_vld[3]), .out_ready(out_rdy));
  add_tree_acc #(.ELEMENT_BIT_DEPTH(EBD), .NUM_ELEMENTS(2), .OUT_BIT_DEPTH(15), .SATURATE(0)) u_d4 (
    .clk(clk), .rst_n(rst_n), .addend_array(vec[2*EBD-1:0]), .in_valid(dut_vld),
    .in_first(stim_first), .in_last(stim_last), .in_ready(in_rdy[4]), .out_sum(s4),
    .out_sat(o_sat[4]), .out_valid(o_vld[4]), .out_ready(out_rdy));

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Block-sum model: per-beat element sum, then clamp or modulo at the output width.
  task automatic model_beat();
    longint s, full, mx;
    bit ovf;
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      s = 0;
      for (int i = 0; i < NEL[d]; i++) s += longint'(el[i]);
      mx = (longint'(1) << OBD[d]) - 1;
      full = (stim_first ? 0 : acc[d]) + s;
      ovf = full > mx;
      if (!ovf) acc[d] = full;
      else if (SATM[d] != 0) acc[d] = mx;
      else acc[d] = full % (mx + 1);
      sacc[d] = (stim_first ? 1'b0 : sacc[d]) | ovf;
      if (stim_last) begin
        e.sum = acc[d];
        e.sat = sacc[d];
        e.cyc = cyc + LAT[d];
        expq[d].push_back(e);
      end
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      expq[d].delete();
      acc[d] = 0;
      sacc[d] = 1'b0;
      fresh[d] = 1'b1;
    end
  endtask

  // Called and returns at posedge+1; holds the beat until every DUT is ready.
  task automatic send(input bit f, input bit l);
    bit took;
    took = 1'b0;
    stim_vld = 1'b1;
    stim_first = f;
    stim_last = l;
    for (int w = 0; w < 60 && !took; w++) begin
      @(negedge clk);
      if (rdy_all) begin
        model_beat();
        took = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!took && auto_release) out_rdy = 1'b1;
    end
    if (!took) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=%b, expected 11111", in_rdy);
    end
    stim_vld = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    stim_vld = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      done = 1'b1;
      for (int d = 0; d < ND; d++) if (expq[d].size() != 0 || o_vld[d]) done = 1'b0;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: out_valid=%b pending=%0d, expected all delivered", o_vld, expq[0].size());
    end
  endtask

  task automatic set_base();
    for (int i = 0; i < 16; i++) el[i] = base_v[i % 8];
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < ND; d++) begin
        total++;
        if (in_rdy[d] !== (!o_vld[d] || out_rdy)) begin
          bad++;
          $display("FAIL in_ready d%0d cyc %0d: got %b, expected %b", d, cyc, in_rdy[d], (!o_vld[d] || out_rdy));
        end
        if (o_vld[d] === 1'b1) begin
          total++;
          if (expq[d].size() == 0) begin
            bad++;
            $display("FAIL unexpected out_valid d%0d cyc %0d: out_sum=0x%0h", d, cyc, o_sum[d]);
          end else begin
            if (o_sum[d] !== 18'(expq[d][0].sum) || o_sat[d] !== expq[d][0].sat) begin
              bad++;
              $display("FAIL result d%0d cyc %0d: got sum=0x%0h sat=%b, expected sum=0x%0h sat=%b",
                       d, cyc, o_sum[d], o_sat[d], expq[d][0].sum, expq[d][0].sat);
            end
            if (fresh[d] && lat_chk) begin
              total++;
              if (cyc != expq[d][0].cyc) begin
                bad++;
                $display("FAIL latency d%0d: out_valid in cycle %0d, expected cycle %0d", d, cyc, expq[d][0].cyc);
              end
            end
            fresh[d] = 1'b0;
            if (out_rdy) begin
              last_sum[d] = longint'(o_sum[d]);
              last_sat[d] = o_sat[d];
              dcnt[d]++;
              void'(expq[d].pop_front());
              fresh[d] = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    base_v[0] = 14'h0769; base_v[1] = 14'h0182; base_v[2] = 14'h07b9; base_v[3] = 14'h0575;
    base_v[4] = 14'h0668; base_v[5] = 14'h034d; base_v[6] = 14'h0286; base_v[7] = 14'h02d8;
    for (int i = 0; i < 16; i++) el[i] = '0;
    for (int d = 0; d < ND; d++) begin
      dcnt[d] = 0;
      last_sum[d] = 0;
      last_sat[d] = 1'b0;
    end
    model_reset();

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", o_vld, 0);
    chk("reset_out_sat", o_sat, 0);
    for (int d = 0; d < ND; d++) chk($sformatf("reset_out_sum_d%0d", d), o_sum[d], 0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", in_rdy, 5'b11111);
    @(posedge clk);
    #1;

    // Single-beat block
    set_base();
    send(1'b1, 1'b1);
    drain();
    chk("t1_count", dcnt[0], 1);
    chk("t1_sum_n8", last_sum[0], 64'h252C);
    chk("t1_sat_n8", last_sat[0], 0);
    chk("t1_sum_n16", last_sum[3], 64'h4A58);
    chk("t1_sum_n2", last_sum[4], 64'h08EB);

    // Four-beat block
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    drain();
    chk("t2_count", dcnt[0], 2);
    chk("t2_sum_n8", last_sum[0], 64'h94B0);
    chk("t2_sat_n8", last_sat[0], 0);
    chk("t2_sum_o14_sat", last_sum[1], 64'h3FFF);
    chk("t2_sat_o14_sat", last_sat[1], 1);
    chk("t2_sum_o14_wrap", last_sum[2], 64'h14B0);
    chk("t2_sat_o14_wrap", last_sat[2], 1);

    // All-ones beat: saturation and wrap at the narrow output
    for (int i = 0; i < 16; i++) el[i] = 14'h3FFF;
    send(1'b1, 1'b1);
    drain();
    chk("t3_sum_o17", last_sum[0], 64'h1FFF8);
    chk("t3_sat_o17", last_sat[0], 0);
    chk("t3_sum_o14_sat", last_sum[1], 64'h3FFF);
    chk("t3_sat_o14_sat", last_sat[1], 1);
    chk("t3_sum_o14_wrap", last_sum[2], 64'h3FF8);
    chk("t3_sat_o14_wrap", last_sat[2], 1);
    chk("t3_sum_n16", last_sum[3], 64'h1FFFF);
    chk("t3_sat_n16", last_sat[3], 1);
    chk("t3_sum_n2", last_sum[4], 64'h7FFE);
    chk("t3_sat_n2", last_sat[4], 0);

    // Back-to-back single-beat blocks under a 5-cycle output stall
    lat_chk = 1'b0;
    fork
      begin
        out_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_rdy = 1'b1;
      end
      begin
        for (int k = 0; k < 6; k++) begin
          for (int i = 0; i < 16; i++) el[i] = 14'(k * 16 + i);
          send(1'b1, 1'b1);
        end
      end
    join
    drain();
    chk("t4_count", dcnt[0], 9);
    chk("t4_last_sum", last_sum[0], 668);

    // Reset in the middle of a block
    set_base();
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_valid_in_reset", o_vld, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_base();
    send(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) el[i] = 14'h0010;
    send(1'b0, 1'b1);
    drain();
    chk("t5_count", dcnt[0], 10);
    chk("t5_sum", last_sum[0], 64'h25AC);

    // Random vectors and framing, first with free-flowing output then with random back-pressure
    lat_chk = 1'b1;
    for (int b = 0; b < 400; b++) begin
      if (b == 200) begin
        lat_chk = 1'b0;
        auto_release = 1'b1;
      end
      for (int i = 0; i < 16; i++)
        el[i] = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 1023)) : 14'($urandom_range(0, 16383));
      if (b >= 200) out_rdy = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 4) == 0) begin
        stim_vld = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        send($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      end
    end
    out_rdy = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
